// File: rtl/alu_vec_checker.sv
// rtl/alu_vec_checker.sv - vector memory driven checker for op/a/b -> result datapaths
// Optional first-mismatch capture ports: ALU_VEC_CHECKER_FAIL_CAPTURE_EN
module alu_vec_checker #(
  parameter int OP_W   = 4,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32,
  parameter int LAT    = 0,
  parameter int CNT_W  = 11,
  localparam int AW    = $clog2(DEPTH),
  localparam int VEC_W = OP_W + 3 * DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [VEC_W-1:0]  wr_data,
  input  logic [AW:0]       num_vec,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              dut_valid,
  output logic [OP_W-1:0]   dut_op,
  output logic [DATA_W-1:0] dut_a,
  output logic [DATA_W-1:0] dut_b,
  input  logic [DATA_W-1:0] dut_result,
  output logic [CNT_W-1:0]  vec_cnt,
  output logic [CNT_W-1:0]  err_cnt
`ifdef ALU_VEC_CHECKER_FAIL_CAPTURE_EN
  ,
  output logic              fail_valid,
  output logic [AW-1:0]     fail_idx,
  output logic [DATA_W-1:0] fail_got,
  output logic [DATA_W-1:0] fail_exp
`endif
);

  typedef enum logic [2:0] {IDLE, FETCH, RUN, DRAIN, DONE} state_t;

  state_t            state, state_nxt;
  logic [VEC_W-1:0]  mem [DEPTH];
  logic [VEC_W-1:0]  rd_word;
  logic [AW-1:0]     rd_addr;
  logic [AW:0]       run_len;
  logic [AW:0]       run_idx;
  logic              start_ok;
  logic              last_vec;
  logic              cmp_valid;
  logic [DATA_W-1:0] cmp_exp;
  logic              pipe_busy;
  logic              mismatch;

  assign start_ok = start && (state == IDLE || state == DONE);
  assign last_vec = (run_idx == run_len - (AW+1)'(1));

  // While running, prefetch the vector after the one currently presented.
  assign rd_addr = (state == RUN) ? run_idx[AW-1:0] + AW'(1) : '0;

  always_ff @(posedge clk) begin
    if (wr_en && !busy) begin
      mem[wr_addr] <= wr_data;
    end
    rd_word <= mem[rd_addr];
  end

  assign busy      = (state == FETCH) || (state == RUN) || (state == DRAIN);
  assign done      = (state == DONE);
  assign pass      = done && (err_cnt == '0);
  assign dut_valid = (state == RUN);
  assign dut_op    = dut_valid ? rd_word[VEC_W-1 -: OP_W] : '0;
  assign dut_a     = dut_valid ? rd_word[3*DATA_W-1 -: DATA_W] : '0;
  assign dut_b     = dut_valid ? rd_word[2*DATA_W-1 -: DATA_W] : '0;

  generate
    if (LAT == 0) begin : g_comb
      assign cmp_valid = dut_valid;
      assign cmp_exp   = rd_word[DATA_W-1:0];
      assign pipe_busy = 1'b0;
    end else begin : g_pipe
      logic [LAT-1:0]    vpipe;
      logic [DATA_W-1:0] epipe [LAT];

      always_ff @(posedge clk) begin
        if (rst) begin
          vpipe <= '0;
        end else begin
          vpipe[0] <= dut_valid;
          for (int i = 1; i < LAT; i++) begin
            vpipe[i] <= vpipe[i-1];
          end
        end
      end

      // Data needs no reset: only read when the matching tag is set.
      always_ff @(posedge clk) begin
        epipe[0] <= rd_word[DATA_W-1:0];
        for (int i = 1; i < LAT; i++) begin
          epipe[i] <= epipe[i-1];
        end
      end

      assign cmp_valid = vpipe[LAT-1];
      assign cmp_exp   = epipe[LAT-1];
      assign pipe_busy = |vpipe;
    end
  endgenerate

  assign mismatch = cmp_valid && (dut_result != cmp_exp);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nxt = (num_vec == '0) ? DONE : FETCH;
        end
      end
      FETCH:   state_nxt = RUN;
      RUN:     if (last_vec) state_nxt = DRAIN;
      DRAIN:   if (!pipe_busy) state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      run_len <= '0;
      run_idx <= '0;
      vec_cnt <= '0;
      err_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (start_ok) begin
        run_len <= num_vec;
        run_idx <= '0;
        vec_cnt <= '0;
        err_cnt <= '0;
      end else begin
        if (state == RUN) begin
          run_idx <= run_idx + (AW+1)'(1);
        end
        if (cmp_valid) begin
          vec_cnt <= vec_cnt + CNT_W'(1);
        end
        if (mismatch && err_cnt != '1) begin
          err_cnt <= err_cnt + CNT_W'(1);
        end
      end
    end
  end

`ifdef ALU_VEC_CHECKER_FAIL_CAPTURE_EN
  // vec_cnt equals the index of the vector being compared this cycle.
  always_ff @(posedge clk) begin
    if (rst || start_ok) begin
      fail_valid <= 1'b0;
      fail_idx   <= '0;
      fail_got   <= '0;
      fail_exp   <= '0;
    end else if (mismatch && !fail_valid) begin
      fail_valid <= 1'b1;
      fail_idx   <= vec_cnt[AW-1:0];
      fail_got   <= dut_result;
      fail_exp   <= cmp_exp;
    end
  end
`endif

endmodule

// File: tb/tb_alu_vec_checker.sv
// tb/tb_alu_vec_checker.sv - randomized self-checking bench for alu_vec_checker
// Two instances: LAT=0 with combinational ALU, LAT=3 with a registered ALU of selectable depth.
module tb_alu_vec_checker;

  logic        clk;
  logic        rst;
  logic        wr_en0, wr_en3;
  logic [4:0]  wr_addr;
  logic [99:0] wr_data;
  logic [5:0]  num_vec;
  logic        start0, start3;

  logic        busy0, done0, pass0, dut_valid0;
  logic [3:0]  dut_op0;
  logic [31:0] dut_a0, dut_b0, dut_result0;
  logic [10:0] vec_cnt0, err_cnt0;
  logic        busy3, done3, pass3, dut_valid3;
  logic [3:0]  dut_op3;
  logic [31:0] dut_a3, dut_b3, dut_result3;
  logic [10:0] vec_cnt3, err_cnt3;
`ifdef ALU_VEC_CHECKER_FAIL_CAPTURE_EN
  logic        fv0, fv3;
  logic [4:0]  fi0, fi3;
  logic [31:0] fg0, fe0, fg3, fe3;
`endif

  int checks = 0;
  int passed = 0;
  int tb_lat = 3;
  int vcount0 = 0;

  logic [3:0]  m_op [32];
  logic [31:0] m_a [32];
  logic [31:0] m_b [32];
  logic [31:0] m_e [32];
  logic [31:0] r1, r2, r3;

  alu_vec_checker #(.LAT(0)) u0 (
    .clk(clk), .rst(rst), .wr_en(wr_en0), .wr_addr(wr_addr), .wr_data(wr_data),
    .num_vec(num_vec), .start(start0), .busy(busy0), .done(done0), .pass(pass0),
    .dut_valid(dut_valid0), .dut_op(dut_op0), .dut_a(dut_a0), .dut_b(dut_b0),
    .dut_result(dut_result0), .vec_cnt(vec_cnt0), .err_cnt(err_cnt0)
`ifdef ALU_VEC_CHECKER_FAIL_CAPTURE_EN
    , .fail_valid(fv0), .fail_idx(fi0), .fail_got(fg0), .fail_exp(fe0)
`endif
  );

  alu_vec_checker #(.LAT(3)) u3 (
    .clk(clk), .rst(rst), .wr_en(wr_en3), .wr_addr(wr_addr), .wr_data(wr_data),
    .num_vec(num_vec), .start(start3), .busy(busy3), .done(done3), .pass(pass3),
    .dut_valid(dut_valid3), .dut_op(dut_op3), .dut_a(dut_a3), .dut_b(dut_b3),
    .dut_result(dut_result3), .vec_cnt(vec_cnt3), .err_cnt(err_cnt3)
`ifdef ALU_VEC_CHECKER_FAIL_CAPTURE_EN
    , .fail_valid(fv3), .fail_idx(fi3), .fail_got(fg3), .fail_exp(fe3)
`endif
  );

  function automatic logic [31:0] alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return a << b[4:0];
      default: return a + b;
    endcase
  endfunction

  always_comb dut_result0 = alu(dut_op0, dut_a0, dut_b0);

  always @(posedge clk) begin
    r1 <= alu(dut_op3, dut_a3, dut_b3);
    r2 <= r1;
    r3 <= r2;
    if (dut_valid0) vcount0 <= vcount0 + 1;
  end
  assign dut_result3 = (tb_lat == 3) ? r3 : r2;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  function automatic int model_errs(input int n);
    int e = 0;
    for (int i = 0; i < n; i++) if (m_e[i] != alu(m_op[i], m_a[i], m_b[i])) e++;
    return e;
  endfunction

  function automatic int model_first(input int n);
    for (int i = 0; i < n; i++) if (m_e[i] != alu(m_op[i], m_a[i], m_b[i])) return i;
    return -1;
  endfunction

  task automatic load(input int i, input logic [3:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] e);
    m_op[i] = op; m_a[i] = a; m_b[i] = b; m_e[i] = e;
    @(negedge clk);
    wr_en0 = 1; wr_en3 = 1; wr_addr = 5'(i); wr_data = {op, a, b, e};
    @(negedge clk);
    wr_en0 = 0; wr_en3 = 0;
  endtask

  task automatic load_random(input int n);
    logic [3:0] op;
    logic [31:0] a, b, e;
    for (int i = 0; i < n; i++) begin
      op = 4'($urandom_range(0, 7));
      a = $urandom; b = $urandom;
      e = alu(op, a, b);
      if ($urandom_range(0, 3) == 0) e = e ^ (32'd1 << $urandom_range(0, 31));
      load(i, op, a, b, e);
    end
  endtask

  task automatic run(input int sel, input int n, output int cycles);
    @(negedge clk);
    num_vec = 6'(n);
    if (sel == 0) start0 = 1; else start3 = 1;
    @(posedge clk); #1;
    start0 = 0; start3 = 0;
    cycles = 0;
    while (!(sel == 0 ? done0 : done3) && cycles < 200) begin
      @(posedge clk); #1;
      cycles++;
    end
  endtask

  task automatic test_reset;
    @(negedge clk); rst = 1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if ({busy0, done0, pass0, dut_valid0} !== 4'b0) $display("FAIL reset_flags0 got %b exp 0000", {busy0, done0, pass0, dut_valid0}); else passed++;
    checks++; if ({busy3, done3, pass3, dut_valid3} !== 4'b0) $display("FAIL reset_flags3 got %b exp 0000", {busy3, done3, pass3, dut_valid3}); else passed++;
    checks++; if ({dut_op0, dut_a0, dut_b0} !== 68'h0) $display("FAIL reset_dut_bus got %h exp 0", {dut_op0, dut_a0, dut_b0}); else passed++;
    checks++; if ({vec_cnt0, err_cnt0, vec_cnt3, err_cnt3} !== 44'h0) $display("FAIL reset_counters got %h exp 0", {vec_cnt0, err_cnt0, vec_cnt3, err_cnt3}); else passed++;
    @(negedge clk); rst = 0;
  endtask

  task automatic test_adder;
    int c;
    load(0, 4'd0, 32'h1, 32'h2, 32'h3);
    load(1, 4'd0, 32'h5, 32'h7, 32'hC);
    load(2, 4'd0, 32'hFFFFFFFF, 32'h1, 32'h0);
    load(3, 4'd0, 32'h80000000, 32'h80000000, 32'h0);
    run(0, 4, c);
    checks++; if (c !== 6) $display("FAIL adder_cycles got %0d exp 6", c); else passed++;
    checks++; if (vec_cnt0 !== 11'd4) $display("FAIL adder_vec_cnt got %0d exp 4", vec_cnt0); else passed++;
    checks++; if (err_cnt0 !== 11'd0) $display("FAIL adder_err_cnt got %0d exp 0", err_cnt0); else passed++;
    checks++; if (pass0 !== 1'b1 || busy0 !== 1'b0) $display("FAIL adder_pass got %b%b exp 10", pass0, busy0); else passed++;
  endtask

  task automatic test_bad_entry;
    int c;
    load(2, 4'd0, 32'hFFFFFFFF, 32'h1, 32'h1);
    run(0, 4, c);
    checks++; if (err_cnt0 !== 11'(model_errs(4))) $display("FAIL bad_err_cnt got %0d exp %0d", err_cnt0, model_errs(4)); else passed++;
    checks++; if (pass0 !== 1'b0 || done0 !== 1'b1) $display("FAIL bad_pass got %b%b exp 01", pass0, done0); else passed++;
`ifdef ALU_VEC_CHECKER_FAIL_CAPTURE_EN
    checks++; if ({fv0, fi0, fg0, fe0} !== {1'b1, 5'(model_first(4)), 32'h0, 32'h1}) $display("FAIL bad_capture got %b %0d %h %h exp 1 2 0 1", fv0, fi0, fg0, fe0); else passed++;
`endif
  endtask

  task automatic test_zero;
    int c;
    vcount0 = 0;
    run(0, 0, c);
    checks++; if (c !== 0 || done0 !== 1'b1) $display("FAIL zero_done got c=%0d done=%b exp c=0 done=1", c, done0); else passed++;
    checks++; if (pass0 !== 1'b1 || vec_cnt0 !== 11'd0 || err_cnt0 !== 11'd0) $display("FAIL zero_counts got pass=%b vec=%0d err=%0d exp 1 0 0", pass0, vec_cnt0, err_cnt0); else passed++;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (vcount0 !== 0) $display("FAIL zero_dut_valid got %0d exp 0", vcount0); else passed++;
`ifdef ALU_VEC_CHECKER_FAIL_CAPTURE_EN
    checks++; if (fv0 !== 1'b0) $display("FAIL zero_capture_clear got %b exp 0", fv0); else passed++;
`endif
  endtask

  task automatic test_latency;
    int c;
    for (int i = 0; i < 8; i++) load(i, 4'd0, 32'(16 * (i + 1)), 32'(i), 32'(17 * i + 16));
    tb_lat = 3;
    run(3, 8, c);
    checks++; if (c !== 13) $display("FAIL lat3_cycles got %0d exp 13", c); else passed++;
    checks++; if (err_cnt3 !== 11'd0 || vec_cnt3 !== 11'd8 || pass3 !== 1'b1) $display("FAIL lat3_result got err=%0d vec=%0d pass=%b exp 0 8 1", err_cnt3, vec_cnt3, pass3); else passed++;
    tb_lat = 2;
    run(3, 8, c);
    checks++; if (err_cnt3 !== 11'd8 || pass3 !== 1'b0) $display("FAIL lat2_misalign got err=%0d pass=%b exp 8 0", err_cnt3, pass3); else passed++;
    tb_lat = 3;
  endtask

  task automatic test_reset_mid;
    int c;
    for (int i = 0; i < 16; i++) load(i, 4'd0, 32'(i * 3), 32'(i + 100), 32'(i * 4 + 100));
    @(negedge clk);
    num_vec = 6'd16; start0 = 1;
    @(posedge clk); #1;
    start0 = 0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    checks++; if ({busy0, done0, dut_valid0} !== 3'b0) $display("FAIL midrst_flags got %b exp 000", {busy0, done0, dut_valid0}); else passed++;
    checks++; if (vec_cnt0 !== 11'd0 || err_cnt0 !== 11'd0) $display("FAIL midrst_counts got vec=%0d err=%0d exp 0 0", vec_cnt0, err_cnt0); else passed++;
    run(0, 16, c);
    checks++; if (vec_cnt0 !== 11'd16 || err_cnt0 !== 11'd0 || c !== 18) $display("FAIL midrst_rerun got vec=%0d err=%0d c=%0d exp 16 0 18", vec_cnt0, err_cnt0, c); else passed++;
  endtask

  task automatic test_busy_ignore;
    int c;
    @(negedge clk);
    num_vec = 6'd16; start0 = 1;
    @(posedge clk); #1;
    start0 = 0;
    c = 0;
    while (!done0 && c < 200) begin
      if (c == 3) begin
        wr_en0 = 1; wr_addr = 5'd0; wr_data = {4'd1, 32'hDEAD, 32'hBEEF, 32'h1234};
        start0 = 1;
      end else begin
        wr_en0 = 0; start0 = 0;
      end
      @(posedge clk); #1;
      c++;
    end
    wr_en0 = 0; start0 = 0;
    checks++; if (c !== 18 || vec_cnt0 !== 11'd16) $display("FAIL busy_run_len got c=%0d vec=%0d exp 18 16", c, vec_cnt0); else passed++;
    run(0, 16, c);
    checks++; if (err_cnt0 !== 11'(model_errs(16)) || vec_cnt0 !== 11'd16) $display("FAIL busy_mem_kept got err=%0d vec=%0d exp %0d 16", err_cnt0, vec_cnt0, model_errs(16)); else passed++;
  endtask

  task automatic test_random;
    int c, n, e;
    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(1, 32);
      load_random(n);
      e = model_errs(n);
      run(r % 2 == 0 ? 0 : 3, n, c);
      if (r % 2 == 0) begin
        checks++; if (c !== n + 2 || vec_cnt0 !== 11'(n)) $display("FAIL rand0_len got c=%0d vec=%0d exp %0d %0d", c, vec_cnt0, n + 2, n); else passed++;
        checks++; if (err_cnt0 !== 11'(e) || pass0 !== (e == 0)) $display("FAIL rand0_err got err=%0d pass=%b exp %0d", err_cnt0, pass0, e); else passed++;
`ifdef ALU_VEC_CHECKER_FAIL_CAPTURE_EN
        if (e > 0) begin
          checks++; if (fi0 !== 5'(model_first(n)) || fe0 !== m_e[model_first(n)]) $display("FAIL rand0_capture got idx=%0d exp_f=%h exp %0d", fi0, fe0, model_first(n)); else passed++;
        end
`endif
      end else begin
        checks++; if (c !== n + 5 || vec_cnt3 !== 11'(n)) $display("FAIL rand3_len got c=%0d vec=%0d exp %0d %0d", c, vec_cnt3, n + 5, n); else passed++;
        checks++; if (err_cnt3 !== 11'(e) || pass3 !== (e == 0)) $display("FAIL rand3_err got err=%0d pass=%b exp %0d", err_cnt3, pass3, e); else passed++;
      end
    end
  endtask

  initial begin
    rst = 1; wr_en0 = 0; wr_en3 = 0; wr_addr = '0; wr_data = '0;
    num_vec = '0; start0 = 0; start3 = 0;
    test_reset;
    test_adder;
    test_bad_entry;
    test_zero;
    test_latency;
    test_reset_mid;
    test_busy_ignore;
    test_random;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got running exp finished");
    $fatal(1);
  end

endmodule
